// File: rtl/norm_array_if.sv
// norm_array_if: lane data bus between the systolic array output and the
// normalisation stage.
//
// Signals
//   in_data_available  lane-0 input valid (lane i data arrives i cycles later)
//   inp_data           NUM_LANES packed lanes, lane i at [i*DWIDTH +: DWIDTH]
//   validity_mask      1 = normalise lane, 0 = pass lane data unchanged
//   out_data           lane outputs, same packing as inp_data
//   out_lane_valid     per-lane output valid
//   out_data_available copy of out_lane_valid[0]
//
// Handshake: valid-only stream, there is no ready. A lane word is transferred
// in every cycle its valid is high; the consumer must accept it that cycle.
//
// Modports: master drives the inputs and observes the outputs (producer side),
// slave is the normalisation stage itself.
interface norm_array_if #(
    parameter int DWIDTH    = 8,
    parameter int NUM_LANES = 8
);
    logic                          in_data_available;
    logic [NUM_LANES*DWIDTH-1:0]   inp_data;
    logic [NUM_LANES-1:0]          validity_mask;
    logic [NUM_LANES*DWIDTH-1:0]   out_data;
    logic [NUM_LANES-1:0]          out_lane_valid;
    logic                          out_data_available;

    modport master (
        output in_data_available, inp_data, validity_mask,
        input  out_data, out_lane_valid, out_data_available
    );

    modport slave (
        input  in_data_available, inp_data, validity_mask,
        output out_data, out_lane_valid, out_data_available
    );
endinterface

// File: rtl/norm_array.sv
// norm_array: per-lane normalisation y = sat(round((x - mean) * inv_var)).
//
// Ports
//   clk, reset     clock, asynchronous active-high reset
//   enable_norm    1 = two-stage normalise pipeline, 0 = combinational bypass
//   start          one-cycle pulse: latch mean/inv_var/num_cols, clear count
//   mean           signed mean (sampled on start)
//   inv_var        unsigned inverse variance, FRAC_BITS fraction bits
//   num_cols       columns per run (sampled on start)
//   bus            lane data bus (norm_array_if.slave)
//   done_norm      sticky: num_cols columns have left the last lane
//   fsm_state      control FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
//
// Lane i is valid i cycles after lane 0 (skewed valid chain). A normalised
// lane word appears two cycles after its input valid; masked lanes travel the
// same two stages unmodified so all lanes keep the same latency.
module norm_array #(
    parameter int DWIDTH    = 8,
    parameter int NUM_LANES = 8,
    parameter int FRAC_BITS = 4,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_norm,
    input  logic              start,
    input  logic [DWIDTH-1:0] mean,
    input  logic [DWIDTH-1:0] inv_var,
    input  logic [CNT_W-1:0]  num_cols,
    norm_array_if.slave       bus,
    output logic              done_norm,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Product width: (DWIDTH+1)-bit signed diff times DWIDTH-bit unsigned
    // operand, plus a guard bit so the rounding add cannot overflow.
    localparam int PW = 2 * DWIDTH + 2;
    localparam logic signed [PW-1:0] SAT_MAX = PW'(2 ** (DWIDTH - 1) - 1);
    localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX - PW'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   ncols_q;
    logic [DWIDTH-1:0]  mean_q;
    logic [DWIDTH-1:0]  inv_var_q;

    logic [NUM_LANES-1:0]        in_v;
    logic [NUM_LANES-1:0]        lane_v;
    logic [NUM_LANES*DWIDTH-1:0] lane_y;
    logic [NUM_LANES-1:0]        out_v;
    logic                        last_v;

    // ---------------------------------------------------------------
    // Skewed valid chain; runs in both normalise and bypass modes.
    // ---------------------------------------------------------------
    assign in_v[0] = bus.in_data_available;

    if (NUM_LANES > 1) begin : g_skew
        logic [NUM_LANES-2:0] skew_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                skew_q <= '0;
            end else begin
                skew_q <= in_v[NUM_LANES-2:0];
            end
        end

        assign in_v[NUM_LANES-1:1] = skew_q;
    end

    // ---------------------------------------------------------------
    // Lane pipelines
    // ---------------------------------------------------------------
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [DWIDTH-1:0]        x;
        logic signed [DWIDTH:0]   x_ext;
        logic signed [DWIDTH:0]   diff_next;
        logic signed [DWIDTH:0]   diff_q;
        logic                     v1_q;
        logic                     m1_q;
        logic                     v2_q;
        logic [DWIDTH-1:0]        y_q;
        logic signed [PW-1:0]     diff_ext;
        logic signed [PW-1:0]     inv_ext;
        logic signed [PW-1:0]     prod;
        logic signed [PW-1:0]     rnd;
        logic signed [PW-1:0]     shf;
        logic [DWIDTH-1:0]        sat_y;

        assign x         = bus.inp_data[i*DWIDTH +: DWIDTH];
        assign x_ext     = {x[DWIDTH-1], x};
        assign diff_next = x_ext - {mean_q[DWIDTH-1], mean_q};

        assign diff_ext = {{(PW-DWIDTH-1){diff_q[DWIDTH]}}, diff_q};
        assign inv_ext  = {{(PW-DWIDTH){1'b0}}, inv_var_q};
        assign prod     = diff_ext * inv_ext;

        // Round half up, then drop the fraction with an arithmetic shift.
        if (FRAC_BITS > 0) begin : g_rnd
            assign rnd = prod + (PW'(1) <<< (FRAC_BITS - 1));
        end else begin : g_nornd
            assign rnd = prod;
        end
        assign shf = rnd >>> FRAC_BITS;

        always_comb begin
            if (shf > SAT_MAX) begin
                sat_y = SAT_MAX[DWIDTH-1:0];
            end else if (shf < SAT_MIN) begin
                sat_y = SAT_MIN[DWIDTH-1:0];
            end else begin
                sat_y = shf[DWIDTH-1:0];
            end
        end

        // Stage 1: difference (or sign-extended raw x for a masked lane).
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v1_q   <= 1'b0;
                m1_q   <= 1'b0;
                diff_q <= '0;
            end else if (enable_norm && in_v[i]) begin
                v1_q   <= 1'b1;
                m1_q   <= bus.validity_mask[i];
                diff_q <= bus.validity_mask[i] ? diff_next : x_ext;
            end else begin
                v1_q   <= 1'b0;
                m1_q   <= 1'b0;
                diff_q <= '0;
            end
        end

        // Stage 2: scaled, rounded, saturated result (raw x when masked).
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v2_q <= 1'b0;
                y_q  <= '0;
            end else if (enable_norm && v1_q) begin
                v2_q <= 1'b1;
                y_q  <= m1_q ? sat_y : diff_q[DWIDTH-1:0];
            end else begin
                v2_q <= 1'b0;
                y_q  <= '0;
            end
        end

        assign lane_v[i]                   = v2_q;
        assign lane_y[i*DWIDTH +: DWIDTH]  = y_q;
    end

    // Bypass is purely combinational from the inputs and the valid chain.
    assign out_v                  = enable_norm ? lane_v : in_v;
    assign bus.out_lane_valid     = out_v;
    assign bus.out_data           = enable_norm ? lane_y : bus.inp_data;
    assign bus.out_data_available = out_v[0];
    assign last_v                 = out_v[NUM_LANES-1];

    // ---------------------------------------------------------------
    // Control FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. start restarts from any state.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (num_cols == '0) ? DONE : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (last_v && (count_q + CNT_W'(1) == ncols_q)) begin
                        state_d = DONE;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs decoded from the state register, so done_norm is registered.
    always_comb begin
        done_norm = (state_q == DONE);
        fsm_state = state_q;
    end

    // Operand latches and column counter. The counter only advances in RUN
    // and never passes ncols_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mean_q    <= '0;
            inv_var_q <= '0;
            ncols_q   <= '0;
            count_q   <= '0;
        end else if (start) begin
            mean_q    <= mean;
            inv_var_q <= inv_var;
            ncols_q   <= num_cols;
            count_q   <= '0;
        end else if (state_q == RUN && last_v && count_q != ncols_q) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_norm_array.sv
// Bench for norm_array: directed and random columns checked through a
// per-lane expected queue, plus run control, bypass and mid-run reset.
module tb_norm_array;

    localparam int DW = 8;
    localparam int NL = 8;
    localparam int FB = 4;
    localparam int CW = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          enable_norm;
    logic          start;
    logic [DW-1:0] mean;
    logic [DW-1:0] inv_var;
    logic [CW-1:0] num_cols;
    logic          done_norm;
    logic [1:0]    fsm_state;

    norm_array_if #(.DWIDTH(DW), .NUM_LANES(NL)) bus ();

    norm_array #(
        .DWIDTH(DW), .NUM_LANES(NL), .FRAC_BITS(FB), .CNT_W(CW)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .enable_norm (enable_norm),
        .start       (start),
        .mean        (mean),
        .inv_var     (inv_var),
        .num_cols    (num_cols),
        .bus         (bus),
        .done_norm   (done_norm),
        .fsm_state   (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_q [NL][$];
    int            exp_t [NL][$];

    logic [DW-1:0] cols     [16][NL];
    logic [DW-1:0] exp_cols [16][NL];
    logic [NL-1:0] cur_mask;
    logic [DW-1:0] m_mean;
    logic [DW-1:0] m_inv;
    bit            mon_en;
    int            last7_cyc = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: signed diff, unsigned scale, round half up, saturate.
    function automatic logic [DW-1:0] norm_ref(input logic [DW-1:0] x, input logic [DW-1:0] mn,
                                               input logic [DW-1:0] iv, input bit m);
        longint d, p, r;
        if (!m) return x;
        d = longint'($signed(x)) - longint'($signed(mn));
        p = d * longint'(iv);
        if (FB > 0) p = p + (longint'(1) << (FB - 1));
        r = p >>> FB;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r[DW-1:0];
    endfunction

    // ---------------- monitor ----------------
    bit ev_v [NL];
    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            for (int i = 0; i < NL; i++) begin
                while (exp_t[i].size() > 0 && exp_t[i][0] < cyc) begin
                    chk($sformatf("missed_l%0d", i), 64'(cyc), 64'(exp_t[i][0]));
                    void'(exp_t[i].pop_front());
                    void'(exp_q[i].pop_front());
                end
                ev_v[i] = (exp_t[i].size() > 0) && (exp_t[i][0] == cyc);
                chk($sformatf("valid_l%0d", i), 64'(bus.out_lane_valid[i]), 64'(ev_v[i]));
                if (ev_v[i]) begin
                    chk($sformatf("data_l%0d", i), 64'(bus.out_data[i*DW +: DW]), 64'(exp_q[i][0]));
                    void'(exp_t[i].pop_front());
                    void'(exp_q[i].pop_front());
                end
                if (i == NL - 1 && bus.out_lane_valid[i]) last7_cyc = cyc;
            end
            chk("out_data_available", 64'(bus.out_data_available), 64'(ev_v[0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [DW-1:0] mn, input logic [DW-1:0] iv, input logic [CW-1:0] nc);
        @(negedge clk);
        start    = 1'b1;
        mean     = mn;
        inv_var  = iv;
        num_cols = nc;
        m_mean   = mn;
        m_inv    = iv;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic fill_model(input int ncol);
        for (int c = 0; c < ncol; c++)
            for (int i = 0; i < NL; i++) begin
                cols[c][i]     = DW'($urandom_range(0, 255));
                exp_cols[c][i] = norm_ref(cols[c][i], m_mean, m_inv, cur_mask[i]);
            end
    endtask

    // One cycle of the skewed schedule: lane i carries column k-i.
    task automatic drive_cycle(input int k, input int ncol);
        int c;
        @(negedge clk);
        bus.in_data_available = (k < ncol);
        bus.validity_mask     = cur_mask;
        for (int i = 0; i < NL; i++) begin
            c = k - i;
            if (c >= 0 && c < ncol) begin
                bus.inp_data[i*DW +: DW] = cols[c][i];
                exp_q[i].push_back(exp_cols[c][i]);
                exp_t[i].push_back(cyc + 2);
            end else begin
                bus.inp_data[i*DW +: DW] = DW'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic run_cols(input int ncol);
        for (int k = 0; k < ncol + NL - 1; k++) drive_cycle(k, ncol);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_data_available = 1'b0;
        end
    endtask

    task automatic wait_done(output int rise);
        rise = -1;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done_norm) begin
                rise = cyc;
                break;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    logic [NL*DW-1:0] byp_d;
    int               rise;
    int               left;

    initial begin
        rst = 1'b1;
        mon_en = 1'b0;
        enable_norm = 1'b1;
        start = 1'b0;
        mean = '0;
        inv_var = '0;
        num_cols = '0;
        m_mean = '0;
        m_inv = '0;
        cur_mask = '1;
        bus.in_data_available = 1'b0;
        bus.inp_data = '0;
        bus.validity_mask = '1;
        repeat (3) @(negedge clk);

        chk("rst_valid", 64'(bus.out_lane_valid), 64'(0));
        chk("rst_data", 64'(bus.out_data), 64'(0));
        chk("rst_oda", 64'(bus.out_data_available), 64'(0));
        chk("rst_done", 64'(done_norm), 64'(0));
        chk("rst_state", 64'(fsm_state), 64'(ST_IDLE));
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic: mean 10, scale 2.0, x=20 -> 20.
        cur_mask = '1;
        do_start(8'd10, 8'h20, 8'd1);
        fill_model(1);
        cols[0][0] = 8'd20; exp_cols[0][0] = 8'd20;
        run_cols(1);
        idle(4);

        // Rounding: scale 1.5, 3 -> 5, -3 -> -4.
        do_start(8'd0, 8'h18, 8'd1);
        fill_model(1);
        cols[0][0] = 8'd3;  exp_cols[0][0] = 8'd5;
        cols[0][1] = 8'hFD; exp_cols[0][1] = 8'hFC;
        run_cols(1);
        idle(4);

        // Saturation both ways.
        do_start(8'h80, 8'h20, 8'd1);
        fill_model(1);
        cols[0][0] = 8'd127; exp_cols[0][0] = 8'd127;
        run_cols(1);
        idle(4);
        do_start(8'd10, 8'h20, 8'd1);
        fill_model(1);
        cols[0][0] = 8'h9C; exp_cols[0][0] = 8'h80;
        run_cols(1);
        idle(4);

        // Mask 0x0F: upper lanes pass through.
        cur_mask = 8'h0F;
        do_start(8'd5, 8'h18, 8'd1);
        fill_model(1);
        for (int i = 4; i < NL; i++) exp_cols[0][i] = cols[0][i];
        run_cols(1);
        idle(4);

        // Random back-to-back runs.
        for (int r = 0; r < 3; r++) begin
            cur_mask = NL'($urandom_range(0, 255));
            do_start(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), 8'd3);
            fill_model(3);
            run_cols(3);
            idle(4);
        end

        // Run control: four columns.
        cur_mask = '1;
        do_start(8'd3, 8'h10, 8'd4);
        chk("run_state", 64'(fsm_state), 64'(ST_RUN));
        chk("run_done_low", 64'(done_norm), 64'(0));
        fill_model(4);
        run_cols(4);
        wait_done(rise);
        chk("done_rise", 64'(rise), 64'(last7_cyc + 1));
        chk("done_state", 64'(fsm_state), 64'(ST_DONE));
        idle(3);
        chk("done_sticky", 64'(done_norm), 64'(1));

        do_start(8'd0, 8'h10, 8'd2);
        chk("restart_drop", 64'(done_norm), 64'(0));
        do_start(8'd0, 8'h10, 8'd0);
        chk("ncols0_done", 64'(done_norm), 64'(1));
        idle(2);

        // Bypass.
        mon_en = 1'b0;
        enable_norm = 1'b0;
        @(negedge clk);
        byp_d = {$urandom, $urandom};
        bus.inp_data = byp_d;
        bus.in_data_available = 1'b1;
        #1;
        chk("byp_data0", 64'(bus.out_data), 64'(byp_d));
        chk("byp_valid0", 64'(bus.out_lane_valid), 64'(8'h01));
        chk("byp_oda0", 64'(bus.out_data_available), 64'(1));
        @(negedge clk);
        byp_d = {$urandom, $urandom};
        bus.inp_data = byp_d;
        bus.in_data_available = 1'b0;
        #1;
        chk("byp_data1", 64'(bus.out_data), 64'(byp_d));
        chk("byp_valid1", 64'(bus.out_lane_valid), 64'(8'h02));
        idle(NL + 2);
        enable_norm = 1'b1;
        mon_en = 1'b1;
        idle(2);

        // Reset between lane 2 and lane 3 outputs.
        do_start(8'd4, 8'h10, 8'd1);
        fill_model(1);
        for (int k = 0; k <= 4; k++) drive_cycle(k, 1);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(bus.out_lane_valid), 64'(0));
        chk("mid_rst_data", 64'(bus.out_data), 64'(0));
        chk("mid_rst_done", 64'(done_norm), 64'(0));
        chk("mid_rst_state", 64'(fsm_state), 64'(ST_IDLE));
        chk("mid_rst_pending_l3", 64'(exp_q[3].size()), 64'(1));
        for (int i = 0; i < NL; i++) begin
            exp_q[i].delete();
            exp_t[i].delete();
        end
        @(negedge clk);
        rst = 1'b0;
        bus.in_data_available = 1'b0;
        mon_en = 1'b1;
        idle(12);
        chk("post_rst_done", 64'(done_norm), 64'(0));

        left = 0;
        for (int i = 0; i < NL; i++) left += exp_q[i].size();
        chk("sb_empty", 64'(left), 64'(0));

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/norm_array.md
Name: norm_array

Overview:
Parametrised normalisation stage between the systolic array output and the pooling/activation stages.
- Each of NUM_LANES lanes applies (x - mean) * inv_var with fixed-point rounding and signed saturation.
- Supports per-lane masking, a skewed per-lane valid chain, and run control with a programmable column count.
- When disabled it is a transparent combinational bypass.

Parameters:
DWIDTH, 8, data width of every lane, mean and inv_var (two's complement data, unsigned inv_var)
NUM_LANES, 8, number of parallel lanes (>=1)
FRAC_BITS, 4, fractional bits of inv_var (0..DWIDTH-1)
CNT_W, 8, width of the column counter and num_cols

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable_norm  in  1  1 = normalise, 0 = bypass
start  in  1  one-cycle pulse; latches mean/inv_var/num_cols, clears count, begins run
mean  in  DWIDTH  signed mean, sampled on start
inv_var  in  DWIDTH  unsigned inverse variance, UQ(DWIDTH-FRAC_BITS).FRAC_BITS, sampled on start
num_cols  in  CNT_W  columns per run, sampled on start
in_data_available  in  1  lane-0 valid; lane i data arrives i cycles later
inp_data  in  NUM_LANES*DWIDTH  lane i at bits [i*DWIDTH +: DWIDTH]
validity_mask  in  NUM_LANES  1 = normalise lane, 0 = pass lane data unchanged
out_data  out  NUM_LANES*DWIDTH  lane outputs, same packing as inp_data
out_lane_valid  out  NUM_LANES  per-lane output valid
out_data_available  out  1  equals out_lane_valid[0]
done_norm  out  1  sticky; high once num_cols columns have left the last lane

Behaviour:
- Reset (async): all pipeline registers, valid chain and counter go to 0; state = IDLE. Outputs are 0 except bypass paths, which track inputs combinationally.
- Valid skew: in_v[0] = in_data_available; in_v[i] = in_v[i-1] delayed one cycle. The chain runs regardless of enable_norm.
- Lane pipeline (enable_norm=1), per lane i:
  - Stage 1 registers diff = sext(x) - sext(mean_q) at DWIDTH+1 bits.
  - Stage 2 registers y = sat(round(diff * inv_var_q)).
  - round = (p + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift; the add is skipped when FRAC_BITS=0.
  - sat clamps to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
  - Stage registers load only when in_v[i] or the stage-1 valid is high; otherwise they clear to 0.
- Masked lane (validity_mask[i]=0): x passes through both stages unmodified. Latency is identical.
- Latency: lane i input with in_v[i] at cycle t gives out_lane_valid[i] high at t+2.
- Bypass (enable_norm=0): out_data = inp_data and out_lane_valid[i] = in_v[i], both combinational. Pipeline registers are held at 0.
- Control FSM:
  - IDLE: start -> RUN; latch mean_q, inv_var_q, ncols_q; count = 0. If num_cols == 0, go to DONE instead.
  - RUN: count increments on each cycle the last-lane valid is high. The last-lane valid is out_lane_valid[NUM_LANES-1], or in_v[NUM_LANES-1] in bypass. When count reaches ncols_q, go to DONE.
  - DONE: done_norm = 1 (registered, so it rises the cycle after the final last-lane valid). Stays high until start or reset.
  - start in RUN or DONE restarts: count cleared, new operands latched, done_norm drops next cycle.
- Operand stability: data already in the pipeline when start arrives completes with the new mean_q/inv_var_q. Software must issue start only between runs.
- Last-lane valid while IDLE: data is processed using the last latched operands; it is not counted.
- Counter wrap: count saturates at ncols_q; no wrap.
- Reset mid-run: pipeline is flushed immediately, done_norm = 0, state = IDLE.

Test Plan:
- DWIDTH=8, FRAC_BITS=4, start with mean=10, inv_var=0x20 (2.0); lane0 x=20 -> lane0 out=20 at t+2, out_data_available high at t+2 only.
- Rounding: mean=0, inv_var=0x18 (1.5), x=3 -> 5 (4.5 rounds up). x=-3 -> -4 (-4.5+0.5 = -4.0).
- Saturation: mean=-128, inv_var=0x20, x=127 -> 127; mean=10, x=-100 -> -128.
- Skew/mask: NUM_LANES=8, mask=0x0F, one column -> lanes 0-3 normalised, lanes 4-7 equal input. out_lane_valid[i] pulses at t+2+i.
- Run control: num_cols=4, four columns -> done_norm rises one cycle after the 4th out_lane_valid[7]. num_cols=0 -> done_norm high the cycle after start. A second start -> done_norm low next cycle.
- Bypass/reset: enable_norm=0 -> out_data==inp_data in the same cycle. Assert reset between lane 2 and lane 3 outputs -> all valids and done_norm go 0 immediately, with no further outputs.
